// File: rtl/misc_branch_arbiter.sv
// Round-robin arbiter sharing one misc_branch pipeline among n_req lanes.
// Each issued request's lane index is queued in an in-order tag FIFO so the result can be routed back to its lane.
module misc_branch_arbiter #(
    parameter int n_req         = 4,
    parameter int payload_width = 64,
    parameter int result_width  = 46,
    parameter int tag_depth     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [n_req-1:0]                 req_valid,
    output logic [n_req-1:0]                 req_ready,
    input  logic [n_req*payload_width-1:0]   req_payload,
    output logic                             br_in_valid,
    input  logic                             br_in_ready,
    output logic [payload_width-1:0]         br_in_payload,
    input  logic                             br_out_valid,
    output logic                             br_out_ready,
    input  logic [result_width-1:0]          br_out_result,
    output logic [n_req-1:0]                 resp_valid,
    input  logic [n_req-1:0]                 resp_ready,
    output logic [result_width-1:0]          resp_result,
    output logic [$clog2(tag_depth+1)-1:0]   in_flight,
    output logic                             err
);

    localparam int idw = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int cw  = $clog2(tag_depth + 1);
    localparam int pw  = (tag_depth > 1) ? $clog2(tag_depth) : 1;

    logic [idw-1:0] r_rr_ptr;
    logic           r_lock;
    logic [idw-1:0] r_lock_id;
    logic [idw-1:0] r_tags [tag_depth];
    logic [pw-1:0]  r_wr_ptr;
    logic [pw-1:0]  r_rd_ptr;
    logic [cw-1:0]  r_count;
    logic           r_err;

    logic [idw-1:0] w_grant;
    logic           w_found;
    logic           w_active;
    logic           w_has_room;
    logic           w_accept;
    logic           w_nonempty;
    logic [idw-1:0] w_head;
    logic           w_pop;

    // Lane index base+k, wrapped modulo n_req.
    function automatic logic [idw-1:0] lane_add(input logic [idw-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= n_req) s = s - n_req;
        return s[idw-1:0];
    endfunction

    function automatic logic [pw-1:0] ptr_next(input logic [pw-1:0] p);
        return (int'(p) == tag_depth - 1) ? '0 : p + pw'(1);
    endfunction

    always_comb begin
        w_grant = r_lock_id;
        w_found = 1'b0;
        if (!r_lock) begin
            w_grant = '0;
            for (int k = 0; k < n_req; k++) begin
                if (!w_found && req_valid[lane_add(r_rr_ptr, k)]) begin
                    w_grant = lane_add(r_rr_ptr, k);
                    w_found = 1'b1;
                end
            end
        end
    end

    // Room check ignores any same-cycle pop, so resp_ready never reaches req_ready.
    assign w_active    = enable & ~reset;
    assign w_has_room  = r_count < cw'(tag_depth);
    assign br_in_valid = w_active & ((|req_valid) | r_lock) & w_has_room;
    assign w_accept    = br_in_valid & br_in_ready;

    assign w_nonempty   = (r_count != '0);
    assign w_head       = r_tags[r_rd_ptr];
    assign br_out_ready = resp_ready[w_head] & w_nonempty & w_active;
    assign w_pop        = br_out_valid & br_out_ready;

    always_comb begin
        br_in_payload = '0;
        req_ready     = '0;
        resp_valid    = '0;
        for (int i = 0; i < n_req; i++) begin
            if (w_grant == idw'(i)) begin
                br_in_payload = req_payload[i*payload_width +: payload_width];
                req_ready[i]  = w_accept;
            end
            if (w_head == idw'(i)) begin
                resp_valid[i] = br_out_valid & w_nonempty & w_active;
            end
        end
    end

    assign resp_result = br_out_result;
    assign in_flight   = r_count;
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tags[r_wr_ptr] <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else if (enable) begin
            if (w_accept) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
                r_rr_ptr <= lane_add(w_grant, 1);
                r_lock   <= 1'b0;
            end else if (br_in_valid) begin
                // Stalled grant is pinned so payload stays stable until accepted.
                r_lock    <= 1'b1;
                r_lock_id <= w_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + cw'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - cw'(1);
            end
            if ((br_out_valid && !w_nonempty) || (r_lock && !req_valid[r_lock_id])) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_misc_branch_arbiter.sv
// Bench for misc_branch_arbiter: directed scenarios then random traffic, checked
// every cycle against a queue-based model of grant order and result routing.
module tb_misc_branch_arbiter;

  localparam int N  = 4;
  localparam int PW = 16;
  localparam int RW = 12;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*PW-1:0] req_payload;
  logic            br_in_valid;
  logic            br_in_ready;
  logic [PW-1:0]   br_in_payload;
  logic            br_out_valid;
  logic            br_out_ready;
  logic [RW-1:0]   br_out_result;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [RW-1:0]   resp_result;
  logic [CW-1:0]   in_flight;
  logic            err;

  always #5 clk = ~clk;

  misc_branch_arbiter #(
    .n_req(N), .payload_width(PW), .result_width(RW), .tag_depth(D)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
    .br_in_valid(br_in_valid), .br_in_ready(br_in_ready), .br_in_payload(br_in_payload),
    .br_out_valid(br_out_valid), .br_out_ready(br_out_ready), .br_out_result(br_out_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .in_flight(in_flight), .err(err)
  );

  // Reference state: next lane with priority, pinned lane, issued-lane order.
  int         checks = 0;
  int         failures = 0;
  int         m_rr = 0;
  bit         m_lk = 0;
  int         m_lk_id = 0;
  bit         m_err = 0;
  logic [1:0] exp_q[$];
  bit         auto_ret = 1;
  int         last_acc = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int g;
    bit found, act, any, ebiv, acc, ne, ebor, pop;
    int h;
    logic [N-1:0] erq, erv;
    if (auto_ret) br_out_valid = (exp_q.size() > 0);
    br_out_result = RW'($urandom);
    #1;
    act = enable && !reset;
    any = |req_valid;
    g = 0;
    found = 0;
    if (m_lk) g = m_lk_id;
    else
      for (int k = 0; k < N; k++)
        if (!found && req_valid[(m_rr + k) % N]) begin
          g = (m_rr + k) % N;
          found = 1;
        end
    ebiv = act && (any || m_lk) && (exp_q.size() < D);
    acc  = ebiv && br_in_ready;
    erq  = acc ? N'(1 << g) : '0;
    ne   = exp_q.size() > 0;
    h    = ne ? int'(exp_q[0]) : 0;
    erv  = (br_out_valid && ne && act) ? N'(1 << h) : '0;
    ebor = resp_ready[h] && ne && act;
    pop  = br_out_valid && ebor;
    chk("br_in_valid", 64'(br_in_valid), 64'(ebiv));
    if (ebiv) chk("br_in_payload", 64'(br_in_payload), 64'(req_payload[g*PW +: PW]));
    chk("req_ready", 64'(req_ready), 64'(erq));
    chk("resp_valid", 64'(resp_valid), 64'(erv));
    chk("br_out_ready", 64'(br_out_ready), 64'(ebor));
    chk("resp_result", 64'(resp_result), 64'(br_out_result));
    chk("in_flight", 64'(in_flight), 64'(exp_q.size()));
    chk("err", 64'(err), 64'(m_err));
    @(posedge clk);
    if (reset) begin
      m_rr = 0; m_lk = 0; m_err = 0;
      exp_q.delete();
    end else if (enable) begin
      if (m_lk && !req_valid[m_lk_id]) m_err = 1;
      if (br_out_valid && !ne) m_err = 1;
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(2'(g));
        m_rr = (g + 1) % N;
        m_lk = 0;
      end else if (ebiv) begin
        m_lk = 1;
        m_lk_id = g;
      end
    end
    last_acc = acc ? g : -1;
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) req_payload[i*PW +: PW] = PW'($urandom);
  endtask

  initial begin
    reset = 1; enable = 1; req_valid = '0; req_payload = '0;
    br_in_ready = 1; br_out_valid = 0; br_out_result = '0; resp_ready = '1;
    @(posedge clk);
    @(negedge clk);
    // reset state
    repeat (2) step();
    reset = 0;

    // single lane 2 for five cycles
    rand_payload();
    req_valid = 4'b0100;
    repeat (5) step();
    req_valid = '0;
    repeat (3) step();

    // all lanes valid: rotation continues from lane 3
    req_valid = 4'hF;
    repeat (8) begin rand_payload(); step(); end
    req_valid = '0;
    repeat (3) step();

    // branch stall while lane 1 is granted, lane 0 arrives later
    br_in_ready = 0;
    req_valid = 4'b0010;
    repeat (3) step();
    req_valid = 4'b0011;
    req_payload[0 +: PW] = PW'($urandom);
    step();
    br_in_ready = 1;
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (3) step();

    // tag FIFO fills with responders blocked, then drains
    resp_ready = '0;
    req_valid = 4'hF;
    repeat (5) step();
    resp_ready = '1;
    repeat (4) step();
    req_valid = '0;
    repeat (4) step();

    // result arriving with no tag outstanding
    auto_ret = 0;
    br_out_valid = 1;
    step();
    br_out_valid = 0;
    repeat (3) step();

    // reset mid-operation with three in flight
    reset = 1; step(); reset = 0;
    auto_ret = 1;
    resp_ready = '0;
    req_valid = 4'hF;
    repeat (4) step();
    reset = 1; step(); reset = 0;
    req_valid = 4'b1010;
    step();
    resp_ready = '1;
    req_valid = '0;
    repeat (4) step();

    // locked lane withdraws its request
    br_in_ready = 0;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    br_in_ready = 1;
    repeat (4) step();
    reset = 1; step(); reset = 0;

    // enable low freezes everything
    enable = 0;
    req_valid = 4'hF;
    repeat (3) step();
    enable = 1;
    repeat (3) step();
    req_valid = '0;
    repeat (4) step();

    // random traffic with well-behaved requesters
    auto_ret = 0;
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      br_in_ready = ($urandom_range(0, 3) != 0);
      resp_ready = N'($urandom);
      br_out_valid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          req_payload[i*PW +: PW] = PW'($urandom);
        end else if (last_acc == i) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_payload[i*PW +: PW] = PW'($urandom);
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/misc_branch_arbiter.md
# misc_branch_arbiter

Round-robin arbiter that lets `n_req` requester lanes share one `misc_branch` pipeline. It forwards one granted request per cycle into the branch and records the requester index in an in-order tag FIFO. When each result leaves the branch, the arbiter returns it to the requester that issued it. It sits between the instruction dispatch lanes and a single `misc_branch` instance, and adds zero cycles of forward or return latency.

## Interface
Parameters:
- `n_req`, 4: number of requester lanes, ≥ 2.
- `payload_width`, 64: width of the request bundle forwarded to the branch (block, op, args, acc, shift, dest, commit fields, packed by the instantiator).
- `result_width`, 46: width of the branch output bundle (block, dest, result, commit fields).
- `tag_depth`, 4: tag FIFO depth, ≥ 1. Must be ≥ 3 (branch occupancy) for full throughput.

Ports (`idw = $clog2(n_req)`):
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: global run; when low, the block holds all state and performs no transfers.
- `req_valid`, in, `n_req`: per-lane request valid.
- `req_ready`, out, `n_req`: per-lane request accepted.
- `req_payload`, in, `n_req*payload_width`: lane i at bits `[i*payload_width +: payload_width]`.
- `br_in_valid`, out, 1: drives `misc_branch.in_valid`.
- `br_in_ready`, in, 1: from `misc_branch.in_ready`.
- `br_in_payload`, out, `payload_width`: granted lane's payload.
- `br_out_valid`, in, 1: from `misc_branch.out_valid`.
- `br_out_ready`, out, 1: drives `misc_branch.out_ready`.
- `br_out_result`, in, `result_width`: branch output bundle.
- `resp_valid`, out, `n_req`: per-lane result valid (one-hot or zero).
- `resp_ready`, in, `n_req`: per-lane result accept.
- `resp_result`, out, `result_width`: `br_out_result` broadcast to all lanes.
- `in_flight`, out, `$clog2(tag_depth+1)`: tag FIFO occupancy.
- `err`, out, 1: sticky protocol error.

## Operation
**State:**
- `rr_ptr` (`idw` bits).
- `lock` flag and `lock_id`.
- Tag FIFO: `tag_depth` × `idw` entries, with read and write pointers and a count.
- `err`.

**Grant:**
- If `lock`=1, grant = `lock_id`.
- Otherwise, grant = the first lane with `req_valid` set, searching from `rr_ptr` upward modulo `n_req`.

**Issue:**
- `br_in_valid` = `enable` & ~`reset` & (any `req_valid`, or `lock`) & (`in_flight` < `tag_depth`).
- `br_in_payload` = `req_payload` of the granted lane.
- `req_ready[g]` = `br_in_valid` & `br_in_ready` for the granted lane g. All other lanes see 0.

**Accept** (`br_in_valid` & `br_in_ready`):
- Push g into the tag FIFO.
- `rr_ptr` ← (g+1) mod `n_req`.
- `lock` ← 0.

**Stall:** if `br_in_valid`=1 and `br_in_ready`=0, set `lock` ← 1 and `lock_id` ← g. This keeps the grant and payload stable until accept.

**Return:**
- The head tag h selects the lane.
- `resp_valid[h]` = `br_out_valid` & FIFO non-empty & `enable`.
- `br_out_ready` = `resp_ready[h]` & FIFO non-empty & `enable`.
- On transfer, pop the FIFO.

**Occupancy:**
- Push is allowed only when `in_flight` < `tag_depth`; a same-cycle pop does not enable push.
- Simultaneous push and pop leaves `in_flight` unchanged.

**Errors:**
- `br_out_valid`=1 while the FIFO is empty sets `err`=1 (sticky until reset). The result is not acknowledged.
- A requester dropping `req_valid` while locked sets `err`=1. The lock is held and the stale payload is still issued.

**Reset and enable:**
- `enable`=0: all valid and ready outputs are 0 and no state changes.
- Reset mid-operation discards all tags. `misc_branch` must be reset in the same cycle.

## Timing
- Reset values: `rr_ptr`=0, `lock`=0, FIFO empty, `in_flight`=0, `err`=0. While `reset`=1, all valid and ready outputs are 0.
- Forward path is combinational: request → `br_in_*` in the same cycle. Return path is combinational: `br_out_*` → `resp_*` in the same cycle.
- Sustained throughput is 1 accept per cycle when `tag_depth` ≥ 3 and responders are always ready.
- There is no combinational path from `resp_ready` to `req_ready`.
- `in_flight` updates on the edge after a push or pop.

## Test plan
- **Single lane:** lane 2 holds valid for 5 cycles, branch always ready → 5 accepts on consecutive cycles; after branch latency, 5 results with only `resp_valid[2]`=1; `rr_ptr`=3 after the last accept.
- **All lanes valid:** `n_req`=4, all lanes valid continuously → grant order 0,1,2,3,0,…; each result returns to the matching lane in issue order.
- **Branch stall:** `br_in_ready`=0 for 3 cycles while lane 1 is granted, then lane 0 raises valid → grant stays 1 and payload is stable; lane 1 is accepted first, then lane 0.
- **FIFO full:** `tag_depth`=2, all `resp_ready`=0 → `br_in_valid` drops after 2 accepts and `in_flight`=2; raising `resp_ready` pops and issue resumes the cycle after `in_flight` becomes 1.
- **Protocol error:** `br_out_valid`=1 with the FIFO empty → `err`=1 next cycle, `br_out_ready`=0; `err` stays 1 until reset.
- **Reset mid-operation:** assert `reset` with `in_flight`=3 → next cycle `in_flight`=0, `rr_ptr`=0 and all outputs 0; the first request after release is granted from lane 0 priority.
